// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic MIPS instruction requests into 32-bit words
// and writes them sequentially into instruction memory, one word per request.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    input  logic              start,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                err_ill_q, err_ill_d;
    logic                err_full_q, err_full_d;
    logic [32:0]         enc;

    // Returns {legal, word}; legal=0 for kinds outside the supported set.
    function automatic logic [32:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [32:0] r;
        r = 33'd0;
        case (kind)
            4'd0: r = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1: r = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2: r = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3: r = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4: r = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5: r = {1'b1, 6'b100011, rs, rt, imm};
            4'd6: r = {1'b1, 6'b101011, rs, rt, imm};
            4'd7: r = {1'b1, 6'b000100, rs, rt, imm};
            4'd8: r = {1'b1, 6'b001000, rs, rt, imm};
            4'd9: r = {1'b1, 6'b000010, target};
            default: r = 33'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        err_ill_d  = err_ill_q;
        err_full_d = err_full_q;
        enc        = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (enc[32]) begin
                        wdata_d = enc[31:0];
                        last_d  = in_last;
                        state_d = S_WRITE;
                    end else begin
                        err_ill_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                waddr_d = waddr_q + 1'b1;
                count_d = count_q + 1'b1;
                // A last word landing on the final address is a clean finish.
                if (last_q) begin
                    state_d = S_DONE;
                end else if (&waddr_q) begin
                    err_full_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                if (start) begin
                    waddr_d    = '0;
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_full_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_LOAD;
            waddr_q    <= '0;
            count_q    <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            err_ill_q  <= err_ill_d;
            err_full_q <= err_full_d;
        end
    end

    // Handshake and write strobe come straight from the state register.
    assign in_ready    = (state_q == S_LOAD);
    assign we          = (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign count       = count_q;
    assign err_illegal = err_ill_q;
    assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against an arithmetic
// reference encoder and an address/word scoreboard.
module tb_instr_encoder;

    typedef struct {
        int kind;
        int rs;
        int rt;
        int rd;
        int imm;
        int tgt;
        bit last;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vld1, vld2;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        start;

    logic        rdy1, we1, done1, eill1, efull1;
    logic [5:0]  waddr1;
    logic [31:0] wdata1;
    logic [6:0]  count1;

    logic        rdy2, we2, done2, eill2, efull2;
    logic [1:0]  waddr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [37:0] obs1[$];
    int          wcyc1[$];
    logic [33:0] obs2[$];
    logic [37:0] exp1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(vld1), .in_ready(rdy1),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .start(start),
        .we(we1), .waddr(waddr1), .wdata(wdata1), .count(count1), .done(done1),
        .err_illegal(eill1), .err_full(efull1)
    );

    instr_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(vld2), .in_ready(rdy2),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .start(start),
        .we(we2), .waddr(waddr2), .wdata(wdata2), .count(count2), .done(done2),
        .err_illegal(eill2), .err_full(efull2)
    );

    always @(negedge clk) begin
        if (we1) begin
            obs1.push_back({waddr1, wdata1});
            wcyc1.push_back(cyc);
        end
        if (we2) obs2.push_back({waddr2, wdata2});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference encoding built from opcode/funct numbers and field weights.
    function automatic logic [31:0] ref_enc(input req_t r);
        int     fn_tab[5] = '{32, 34, 36, 37, 42};
        int     op_tab[5] = '{35, 43, 4, 8, 2};
        longint w;
        if (r.kind < 5)
            w = longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048 + fn_tab[r.kind];
        else if (r.kind == 9)
            w = 2 * 67108864 + longint'(r.tgt);
        else
            w = longint'(op_tab[r.kind - 5]) * 67108864 + longint'(r.rs) * 2097152 +
                longint'(r.rt) * 65536 + longint'(r.imm);
        return w[31:0];
    endfunction

    function automatic req_t rand_req(input bit last);
        req_t r;
        r.kind = int'($urandom_range(0, 9));
        r.rs   = int'($urandom_range(0, 31));
        r.rt   = int'($urandom_range(0, 31));
        r.rd   = int'($urandom_range(0, 31));
        r.imm  = int'($urandom_range(0, 65535));
        r.tgt  = int'($urandom_range(0, 67108863));
        r.last = last;
        return r;
    endfunction

    function automatic req_t mk(input int kind, input int rs, input int rt, input int rd,
                                input int imm, input int tgt, input bit last);
        req_t r;
        r.kind = kind; r.rs = rs; r.rt = rt; r.rd = rd;
        r.imm = imm; r.tgt = tgt; r.last = last;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance, valid still high.
    task automatic send(input req_t r, input bit sel);
        int n = 0;
        in_kind   = 4'(r.kind);
        in_rs     = 5'(r.rs);
        in_rt     = 5'(r.rt);
        in_rd     = 5'(r.rd);
        in_imm    = 16'(r.imm);
        in_target = 26'(r.tgt);
        in_last   = r.last;
        if (sel) vld2 = 1'b1; else vld1 = 1'b1;
        while (!(sel ? rdy2 : rdy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        vld1 = 1'b0;
        vld2 = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic restart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        obs1.delete();
        wcyc1.delete();
        exp1.delete();
        obs2.delete();
    endtask

    task automatic run_prog(input string tag, input int len, input bit gaps);
        req_t r;
        for (int i = 0; i < len; i++) begin
            r = rand_req(i == len - 1);
            exp1.push_back({6'(i), ref_enc(r)});
            send(r, 1'b0);
            if (gaps && ($urandom_range(0, 1) == 1)) idle(int'($urandom_range(1, 3)));
        end
        idle(0);
        wait_done1();
        chk({tag, "_nwrites"}, 64'(obs1.size()), 64'(exp1.size()));
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            chk({tag, "_word"}, 64'(obs1[i]), 64'(exp1[i]));
        chk({tag, "_count"}, 64'(count1), 64'(len));
        chk({tag, "_errs"}, {62'd0, eill1, efull1}, 64'd0);
    endtask

    initial begin
        logic [31:0] fixed_exp[5] = '{32'h8E0A0004, 32'hAFBF0000, 32'h1022FFFF, 32'h20080005, 32'h08000010};
        req_t        fixed[5];
        reset = 1'b0; vld1 = 1'b0; vld2 = 1'b0; start = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we", 64'(we1), 64'd0);
        chk("rst_outs", {count1, waddr1, wdata1, done1, eill1, efull1}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(rdy1), 64'd1);

        // Single add
        send(mk(0, 17, 18, 8, 0, 0, 1'b1), 1'b0);
        idle(0);
        chk("add_we", 64'(we1), 64'd1);
        chk("add_ready_in_write", 64'(rdy1), 64'd0);
        chk("add_addr_word", {waddr1, wdata1}, {6'd0, 32'h02324020});
        @(negedge clk);
        chk("add_done", {done1, eill1, efull1}, {61'd0, 3'b100});
        chk("add_count", 64'(count1), 64'd1);
        chk("add_nwrites", 64'(obs1.size()), 64'd1);

        // Fixed I-type/J sequence
        restart();
        fixed[0] = mk(5, 16, 10, 0, 4, 0, 1'b0);
        fixed[1] = mk(6, 29, 31, 0, 0, 0, 1'b0);
        fixed[2] = mk(7, 1, 2, 0, 16'hFFFF, 0, 1'b0);
        fixed[3] = mk(8, 0, 8, 0, 5, 0, 1'b0);
        fixed[4] = mk(9, 0, 0, 0, 0, 26'h10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(fixed[i], 1'b0);
            idle(1);
        end
        wait_done1();
        chk("seq_nwrites", 64'(obs1.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs1.size(); i++)
            chk("seq_word", 64'(obs1[i]), {26'd0, 6'(i), fixed_exp[i]});
        chk("seq_count", 64'(count1), 64'd5);

        // Continuous valid: one write every two cycles
        restart();
        run_prog("cont", 6, 1'b0);
        for (int i = 1; i < wcyc1.size(); i++)
            chk("cont_spacing", 64'(wcyc1[i] - wcyc1[i-1]), 64'd2);

        // Random programs with random gaps
        for (int p = 0; p < 3; p++) begin
            restart();
            run_prog("rand", int'($urandom_range(1, 8)), 1'b1);
        end

        // Illegal kind as second request
        restart();
        send(mk(1, 3, 4, 5, 0, 0, 1'b0), 1'b0);
        send(mk(12, 0, 0, 0, 0, 0, 1'b0), 1'b0);
        idle(3);
        chk("ill_flags", {done1, eill1, efull1}, {61'd0, 3'b110});
        chk("ill_count", 64'(count1), 64'd1);
        chk("ill_nwrites", 64'(obs1.size()), 64'd1);

        // Start during WRITE, seen on the edge entering DONE, is ignored
        restart();
        chk("start_clr", {count1, eill1, rdy1}, {55'd0, 7'd0, 1'b0, 1'b1});
        send(mk(4, 7, 8, 9, 0, 0, 1'b1), 1'b0);
        idle(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored", {done1, count1}, {56'd0, 1'b1, 7'd1});

        // Small memory fills before last
        for (int i = 0; i < 4; i++) send(rand_req(1'b0), 1'b1);
        idle(1);
        in_kind = 4'd0;
        vld2 = 1'b1;
        repeat (5) @(negedge clk);
        chk("full_ready", 64'(rdy2), 64'd0);
        vld2 = 1'b0;
        chk("full_nwrites", 64'(obs2.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs2.size(); i++)
            chk("full_addr", 64'(obs2[i][33:32]), 64'(i));
        chk("full_flags", {done2, eill2, efull2, count2}, {58'd0, 3'b101, 3'd4});

        // last on the final address is a clean finish
        restart();
        for (int i = 0; i < 4; i++) send(rand_req(i == 3), 1'b1);
        idle(2);
        chk("lastfull_flags", {done2, efull2, count2}, {59'd0, 2'b10, 3'd4});

        // Reset during WRITE
        restart();
        send(rand_req(1'b0), 1'b0);
        idle(0);
        chk("rw_we_before", 64'(we1), 64'd1);
        #2 reset = 1'b0;
        #1 chk("rw_we_async", 64'(we1), 64'd0);
        chk("rw_outs", {count1, waddr1, wdata1, done1, eill1, efull1}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        obs1.delete();
        exp1.delete();
        @(negedge clk);
        run_prog("postrst", 3, 1'b1);

        // Error then start clears everything
        restart();
        send(mk(15, 0, 0, 0, 0, 0, 1'b0), 1'b0);
        idle(1);
        chk("err_set", {done1, eill1}, 64'd3);
        restart();
        chk("err_clr", {done1, eill1, efull1, count1, rdy1}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader that turns a stream of symbolic instruction requests into 32-bit MIPS machine words and writes them, one per word address, into instruction memory. It covers exactly the instruction set the main decoder accepts: R-type add/sub/and/or/slt, lw, sw, beq, addi and j. It sits between the testbench or boot source and the instruction memory write port, ahead of the processor.

## Interface
- ADDR_W, 6, instruction-memory word-address width; depth = 2^ADDR_W words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request this cycle
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate for I-type
- in_target  in  26  jump target field
- in_last  in  1  request is the final instruction of the program
- start  in  1  restart pulse, honoured only in DONE
- we  out  1  imem write enable, one-cycle pulse
- waddr  out  ADDR_W  imem word address
- wdata  out  32  encoded instruction
- count  out  ADDR_W+1  number of words written
- done  out  1  load finished
- err_illegal  out  1  sticky: illegal in_kind received
- err_full  out  1  sticky: memory filled before in_last

## Operation
- States: LOAD, WRITE, DONE. Reset enters LOAD.
- LOAD: in_ready=1. When in_valid=1, the request is accepted.
  - Legal kind: the encoded word is latched into wdata, in_last is latched, and the next state is WRITE.
  - Illegal kind: err_illegal is set, nothing is written, and the next state is DONE.
- Encoding (op, fields):
  - R-type: {000000, rs, rt, rd, 00000, funct}, with funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - ADDI: {001000, rs, rt, imm}.
  - J: {000010, target}.
  - Fields not used by a kind are ignored.
- WRITE: we=1 for exactly one cycle at the current waddr. At the end of the cycle, waddr increments (wraps to 0) and count increments. Next state:
  - DONE if the latched last=1;
  - else DONE with err_full=1 if waddr was 2^ADDR_W-1;
  - else LOAD.
- If last=1 arrives on the final address, the next state is DONE with err_full=0.
- DONE: done=1, in_ready=0, we=0. On start=1: waddr, count, err_illegal and err_full clear to 0, and the next state is LOAD. start is ignored in LOAD and WRITE.
- Reset values: state LOAD, we 0, waddr 0, wdata 0, count 0, done 0, err_illegal 0, err_full 0. in_ready is 1 once reset deasserts.

## Timing
- in_ready and done are decoded from the state register. we is registered, or decoded from state WRITE; either is acceptable as long as it has no combinational path from in_*.
- Request accepted at edge k → we=1 with valid waddr/wdata during cycle k..k+1 → memory captures at edge k+1. count is updated at edge k+1.
- Throughput: one instruction per 2 cycles. in_ready is 0 during WRITE.
- wdata and waddr remain stable while we=1. Both hold their last values in LOAD and DONE.
- Reset asserted mid-WRITE forces we=0 immediately, without waiting for clk. No partial write is counted.
- start arriving in the same cycle as entry into DONE is ignored; it is sampled only while the state is DONE.

## Test plan
- Single add, rs=17 rt=18 rd=8, in_last=1:
  - we pulses once with waddr=0, wdata=0x02324020.
  - done=1 two cycles after acceptance, count=1, no errors.
- Sequence lw (rs=16, rt=10, imm=4), sw (rs=29, rt=31, imm=0), beq (rs=1, rt=2, imm=0xFFFF), addi (rs=0, rt=8, imm=5), j (target=0x10, last):
  - writes 0x8E0A0004, 0xAFBF0000, 0x1022FFFF, 0x20080005, 0x08000010 at addresses 0-4; count=5.
- in_valid held high continuously:
  - in_ready alternates 1,0; exactly one we per two cycles; no request is dropped or duplicated.
- in_kind=12 as the second request:
  - the first word is written; err_illegal=1; done=1; count=1; no second we.
- ADDR_W=2, 5 requests without last:
  - 4 writes at addresses 0-3; DONE with err_full=1, count=4; the 5th request is never accepted.
- Assert reset during WRITE:
  - we drops asynchronously and all outputs return to reset values.
  - After release, a start-free load begins at waddr=0.
  - A start pulse in DONE clears errors and count and re-enters LOAD.
